// File: rtl/alu_exec_unit.sv
// ALU execute stage: one-cycle logic/arith ops, iterative 1-bit/cycle shifts,
// registered result plus compare flags, valid/ready handshake on both sides.
// Ports: clk, reset_n (async, active low); in_valid/in_ready, alu_operation,
//   operand_a, operand_b (request side); out_valid/out_ready, result, zero,
//   lt_signed, lt_unsigned, illegal_op (result side).
module alu_exec_unit #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_operation,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              lt_signed,
    output logic              lt_unsigned,
    output logic              illegal_op
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_BCU  = 4'b1010;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]          op_q, op_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                zero_q, zero_d;
    logic                lts_q, lts_d;
    logic                ltu_q, ltu_d;
    logic                ill_q, ill_d;

    logic                lts_c, ltu_c, ill_c, is_shift_c;
    logic [SHAMT_W-1:0]  shamt_c;
    logic [DATA_W-1:0]   res_c, acc_step;

    assign lts_c   = $signed(operand_a) < $signed(operand_b);
    assign ltu_c   = operand_a < operand_b;
    assign shamt_c = operand_b[SHAMT_W-1:0];
    assign is_shift_c = (alu_operation == OP_SLL) ||
                        (alu_operation == OP_SRL) ||
                        (alu_operation == OP_SRA);

    // Single-cycle result; shifts by zero pass operand_a straight through.
    always_comb begin
        res_c = '0;
        ill_c = 1'b0;
        case (alu_operation)
            OP_ADD:  res_c = operand_a + operand_b;
            OP_SUB:  res_c = operand_a - operand_b;
            OP_AND:  res_c = operand_a & operand_b;
            OP_OR:   res_c = operand_a | operand_b;
            OP_XOR:  res_c = operand_a ^ operand_b;
            OP_SLL:  res_c = operand_a;
            OP_SLT:  res_c = {{(DATA_W-1){1'b0}}, lts_c};
            OP_SLTU: res_c = {{(DATA_W-1){1'b0}}, ltu_c};
            OP_SRL:  res_c = operand_a;
            OP_SRA:  res_c = operand_a;
            OP_BCU:  res_c = operand_a - operand_b;
            default: ill_c = 1'b1;
        endcase
    end

    // One-bit shift of the accumulator, direction/fill from the latched code.
    always_comb begin
        acc_step = acc_q;
        case (op_q)
            OP_SLL:  acc_step = {acc_q[DATA_W-2:0], 1'b0};
            OP_SRL:  acc_step = {1'b0, acc_q[DATA_W-1:1]};
            OP_SRA:  acc_step = {acc_q[DATA_W-1], acc_q[DATA_W-1:1]};
            default: acc_step = acc_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
        lts_d    = lts_q;
        ltu_d    = ltu_q;
        ill_d    = ill_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d  = alu_operation;
                    lts_d = lts_c;
                    ltu_d = ltu_c;
                    ill_d = ill_c;
                    if (is_shift_c && (shamt_c != '0)) begin
                        acc_d   = operand_a;
                        cnt_d   = shamt_c;
                        state_d = SHIFT;
                    end else begin
                        result_d = res_c;
                        zero_d   = (res_c == '0);
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
                acc_d = acc_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d = acc_step;
                    zero_d   = (acc_step == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            lts_q    <= 1'b0;
            ltu_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            lts_q    <= lts_d;
            ltu_q    <= ltu_d;
            ill_q    <= ill_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign result      = result_q;
    assign zero        = zero_q;
    assign lt_signed   = lts_q;
    assign lt_unsigned = ltu_q;
    assign illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: handshake timing,
// shift latency, flags, illegal codes, mid-op reset and back-to-back requests.
module tb_alu_exec_unit;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_operation;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        lt_signed;
    logic        lt_unsigned;
    logic        illegal_op;

    int checks   = 0;
    int failures = 0;

    alu_exec_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_operation(alu_operation),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .zero         (zero),
        .lt_signed    (lt_signed),
        .lt_unsigned  (lt_unsigned),
        .illegal_op   (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
        alu_operation = op;
        operand_a     = a;
        operand_b     = b;
        in_valid      = 1'b1;
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_ovalid_clr"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_iready_set"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        reset_n       = 1'b0;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        alu_operation = 4'd0;
        operand_a     = '0;
        operand_b     = '0;
        #23;
        reset_n = 1'b1;
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {28'd0, zero, lt_signed, lt_unsigned, illegal_op},
            32'd0);

        // add wraps to zero; result held under backpressure
        req(4'b0000, 32'hFFFF_FFFF, 32'd1);
        step();
        in_valid  = 1'b0;
        operand_a = 32'h5555_5555;
        chk("add_ovalid", {31'd0, out_valid}, 32'd1);
        chk("add_result", result, 32'd0);
        chk("add_flags", {28'd0, zero, lt_signed, lt_unsigned, illegal_op},
            32'b1100);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("add_hold_ovalid", {31'd0, out_valid}, 32'd1);
            chk("add_hold_result", result, 32'd0);
        end
        release_out("add");

        // sra by 4 (upper shamt bits ignored): 4-cycle latency
        req(4'b1001, 32'h8000_0000, 32'h0000_0104);
        step();
        in_valid  = 1'b0;
        operand_a = 32'h0;
        operand_b = 32'h1F;
        for (int i = 0; i < 4; i++) begin
            chk("sra_busy_ovalid", {31'd0, out_valid}, 32'd0);
            chk("sra_busy_iready", {31'd0, in_ready}, 32'd0);
            step();
        end
        chk("sra_ovalid", {31'd0, out_valid}, 32'd1);
        chk("sra_result", result, 32'hF800_0000);
        chk("sra_flags", {28'd0, zero, lt_signed, lt_unsigned, illegal_op},
            32'b0100);
        release_out("sra");

        // sll by zero completes in one cycle
        req(4'b0101, 32'h0000_1234, 32'h0000_0000);
        step();
        in_valid = 1'b0;
        chk("sll0_ovalid", {31'd0, out_valid}, 32'd1);
        chk("sll0_result", result, 32'h0000_1234);
        release_out("sll0");

        // unsigned branch compare
        req(4'b1010, 32'd2, 32'd5);
        step();
        in_valid = 1'b0;
        chk("bcu_ovalid", {31'd0, out_valid}, 32'd1);
        chk("bcu_result", result, 32'hFFFF_FFFD);
        chk("bcu_flags", {28'd0, zero, lt_signed, lt_unsigned, illegal_op},
            32'b0110);
        release_out("bcu");

        // illegal code
        req(4'b1110, 32'd7, 32'd9);
        step();
        in_valid = 1'b0;
        chk("ill_ovalid", {31'd0, out_valid}, 32'd1);
        chk("ill_result", result, 32'd0);
        chk("ill_flag", {31'd0, illegal_op}, 32'd1);
        chk("ill_zero", {31'd0, zero}, 32'd1);
        release_out("ill");

        // reset in the middle of a long srl
        req(4'b1000, 32'hFFFF_FFFF, 32'd31);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("srl_busy_ovalid", {31'd0, out_valid}, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("midrst_ovalid", {31'd0, out_valid}, 32'd0);
        chk("midrst_iready", {31'd0, in_ready}, 32'd1);
        chk("midrst_result", result, 32'd0);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step();
            chk("postrst_ovalid", {31'd0, out_valid}, 32'd0);
        end

        // slt after reset
        req(4'b0110, 32'hFFFF_FFFD, 32'd2);
        step();
        in_valid = 1'b0;
        chk("slt_ovalid", {31'd0, out_valid}, 32'd1);
        chk("slt_result", result, 32'd1);
        chk("slt_flags", {28'd0, zero, lt_signed, lt_unsigned, illegal_op},
            32'b0100);
        release_out("slt");

        // back-to-back with in_valid and out_ready held high
        out_ready = 1'b1;
        req(4'b0110, 32'hFFFF_FFFF, 32'd0);
        chk("b2b0_iready", {31'd0, in_ready}, 32'd1);
        step();
        chk("b2b0_ovalid", {31'd0, out_valid}, 32'd1);
        chk("b2b0_result", result, 32'd1);
        req(4'b0100, 32'h0000_F0F0, 32'h0000_0FF0);
        step();
        chk("b2b1_gap", {30'd0, out_valid, in_ready}, 32'b01);
        step();
        chk("b2b1_ovalid", {31'd0, out_valid}, 32'd1);
        chk("b2b1_result", result, 32'h0000_FF00);
        req(4'b0110, 32'd5, 32'hFFFF_FFFB);
        step();
        chk("b2b2_gap", {30'd0, out_valid, in_ready}, 32'b01);
        step();
        chk("b2b2_ovalid", {31'd0, out_valid}, 32'd1);
        chk("b2b2_result", result, 32'd0);
        req(4'b0100, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
        step();
        chk("b2b3_gap", {30'd0, out_valid, in_ready}, 32'b01);
        step();
        in_valid = 1'b0;
        chk("b2b3_ovalid", {31'd0, out_valid}, 32'd1);
        chk("b2b3_result", result, 32'h5555_5555);
        step();
        step();
        chk("b2b_no_dup", {30'd0, out_valid, in_ready}, 32'b01);
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
